// File: rtl/tristate_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter_if
// Bundles the request/grant/driver-enable signals between the shared-bus
// arbiter and its requesters.
//   req     : per-requester level request            (requesters -> arbiter)
//   drv_on  : per-requester "actually driving" status (requesters -> arbiter)
//   gnt     : one-hot grant                           (arbiter -> requesters)
//   drv_en  : one-hot tri-state output enable         (arbiter -> requesters)
//   owner   : index of current owner, valid when busy
//   busy    : bus currently owned
//   preempt : one-cycle pulse when ownership is cut by the hold limit
//   bus_err : sticky contention flag
// Modports: master = arbiter side, slave = requester side.
// ---------------------------------------------------------------------------
interface tristate_bus_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int OW = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] drv_on;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] drv_en;
   logic [OW-1:0]    owner;
   logic             busy;
   logic             preempt;
   logic             bus_err;

   modport master (
      input  req, drv_on,
      output gnt, drv_en, owner, busy, preempt, bus_err
   );

   modport slave (
      output req, drv_on,
      input  gnt, drv_en, owner, busy, preempt, bus_err
   );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter
// Round-robin arbiter and driver sequencer for a shared multi-driver wire.
// At most one requester's tri-state enable is high at any time; every release
// is followed by TURN_CYC all-'z turnaround cycles plus one arbitration cycle,
// and a tenure is cut after MAX_HOLD consecutive owned cycles.
// Ports:
//   clk    : single clock, all logic on posedge
//   rst_n  : synchronous, active-low reset
//   bus    : tristate_bus_arbiter_if.master (req, drv_on in; gnt, drv_en,
//            owner, busy, preempt, bus_err out)
// Build option: define BUS_CHECK_EN to include the contention checker that
// drives the sticky bus_err flag; without it drv_on is ignored and bus_err=0.
// ---------------------------------------------------------------------------
module tristate_bus_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 16,
   parameter int TURN_CYC = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tristate_bus_arbiter_if.master bus
);
   localparam int OW = $clog2(N_REQ);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam int TW = $clog2(TURN_CYC + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
   localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYC);

   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

   state_t           state_reg, state_next;
   logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
   logic [TW-1:0]    turn_cnt_reg, turn_cnt_next;
   logic [OW-1:0]    owner_reg, owner_next;
   logic [OW-1:0]    last_owner_reg, last_owner_next;
   logic [N_REQ-1:0] gnt_reg, gnt_next;
   logic             preempt_reg, preempt_next;
   logic             bus_err_reg, bus_err_next;

   logic [OW-1:0]    pick;
   logic             pick_valid;
   logic             release_own;

   // Rotating search starting just after the last owner, so a requester that
   // was just released (preempted or not) is considered last.
   always_comb begin
      logic [OW-1:0] idx;
      pick       = '0;
      pick_valid = 1'b0;
      idx        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = OW'((int'(last_owner_reg) + k) % N_REQ);
         if (!pick_valid && bus.req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   // Owner gives up the bus either voluntarily (req dropped) or at the limit.
   assign release_own = (state_reg == OWN) &&
                        (!bus.req[owner_reg] || hold_cnt_reg == HOLD_LIM);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         hold_cnt_reg   <= '0;
         turn_cnt_reg   <= '0;
         owner_reg      <= '0;
         last_owner_reg <= OW'(N_REQ - 1);  // requester 0 searched first
         gnt_reg        <= '0;
         preempt_reg    <= 1'b0;
         bus_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hold_cnt_reg   <= hold_cnt_next;
         turn_cnt_reg   <= turn_cnt_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         gnt_reg        <= gnt_next;
         preempt_reg    <= preempt_next;
         bus_err_reg    <= bus_err_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = hold_cnt_reg;
      turn_cnt_next   = turn_cnt_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               state_next    = OWN;
               owner_next    = pick;
               hold_cnt_next = HW'(1);
            end
         end
         OWN: begin
            if (release_own) begin
               state_next      = TURN;
               last_owner_next = owner_reg;
               turn_cnt_next   = TURN_LIM;
            end else if (hold_cnt_reg != HOLD_LIM) begin
               hold_cnt_next = hold_cnt_reg + 1'b1;
            end
         end
         TURN: begin
            // Requests are deliberately not looked at here.
            if (turn_cnt_reg <= TW'(1)) begin
               state_next = IDLE;
            end else begin
               turn_cnt_next = turn_cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs plus busy.
   always_comb begin
      gnt_next     = gnt_reg;
      preempt_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               gnt_next = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            end
         end
         OWN: begin
            if (release_own) begin
               gnt_next     = '0;
               preempt_next = bus.req[owner_reg];  // still wanted it: forced cut
            end
         end
         default: gnt_next = '0;
      endcase
   end

`ifdef BUS_CHECK_EN
   // Contention: more than one driver, or a driver without an enable.
   always_comb begin
      bus_err_next = bus_err_reg
                   | (|(bus.drv_on & (bus.drv_on - 1'b1)))
                   | (|(bus.drv_on & ~gnt_reg));
   end
`else
   // drv_on has no consumer when the checker is compiled out.
   logic drv_on_unused;
   assign drv_on_unused = ^bus.drv_on;
   assign bus_err_next  = 1'b0;
`endif

   assign bus.gnt     = gnt_reg;
   assign bus.drv_en  = gnt_reg;  // enable and grant are the same register
   assign bus.owner   = owner_reg;
   assign bus.busy    = (state_reg == OWN);
   assign bus.preempt = preempt_reg;
   assign bus.bus_err = bus_err_reg;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tristate_bus_arbiter
// Self-checking bench for tristate_bus_arbiter (N_REQ=4, MAX_HOLD=16,
// TURN_CYC=1). A behavioural model tracks ownership every cycle; directed
// tables and sequences add hand-derived expectations on top.
// Honours BUS_CHECK_EN for the expected bus_err behaviour.
// ---------------------------------------------------------------------------
module tb_tristate_bus_arbiter;
   localparam int N        = 4;
   localparam int MAX_HOLD = 16;
   localparam int TURN_CYC = 1;
`ifdef BUS_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   tristate_bus_arbiter_if #(.N_REQ(N)) bus_if ();

   tristate_bus_arbiter #(
      .N_REQ   (N),
      .MAX_HOLD(MAX_HOLD),
      .TURN_CYC(TURN_CYC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_cur   = -1;  // current owner, -1 when nobody holds the bus
   int m_ten   = 0;   // cycles owned so far
   int m_quiet = 0;   // turnaround cycles still to pass
   int m_last  = N - 1;
   int m_own   = 0;
   bit m_pre   = 1'b0;
   bit m_err   = 1'b0;

   function automatic logic [N-1:0] m_gnt();
      return (m_cur < 0) ? '0 : 4'(1 << m_cur);
   endfunction

   function automatic void model_step(input bit rst, input logic [N-1:0] r,
                                      input logic [N-1:0] don);
      if (!rst) begin
         m_cur = -1; m_ten = 0; m_quiet = 0; m_last = N - 1;
         m_own = 0; m_pre = 1'b0; m_err = 1'b0;
         return;
      end
      if (CHK && ($countones(don) > 1 || (don & ~m_gnt()) != '0)) m_err = 1'b1;
      m_pre = 1'b0;
      if (m_cur >= 0) begin
         if (!r[m_cur] || m_ten == MAX_HOLD) begin
            m_pre   = r[m_cur];
            m_last  = m_cur;
            m_cur   = -1;
            m_quiet = TURN_CYC;
         end else begin
            m_ten++;
         end
      end else if (m_quiet > 0) begin
         m_quiet--;
      end else if (r != '0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (r[c]) begin
               m_cur = c; m_own = c; m_ten = 1;
               break;
            end
         end
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare DUT against it.
   task automatic cycle(input bit rst, input logic [N-1:0] r, input logic [N-1:0] don);
      rst_n         = rst;
      bus_if.req    = r;
      bus_if.drv_on = don;
      model_step(rst, r, don);
      @(posedge clk);
      #1;
      check("model_gnt",     32'(bus_if.gnt),     32'(m_gnt()));
      check("model_drv_en",  32'(bus_if.drv_en),  32'(m_gnt()));
      check("model_busy",    32'(bus_if.busy),    32'(m_cur >= 0));
      check("model_owner",   32'(bus_if.owner),   32'(m_own));
      check("model_preempt", 32'(bus_if.preempt), 32'(m_pre));
      check("model_bus_err", 32'(bus_if.bus_err), 32'(m_err));
   endtask

   typedef struct {
      bit         rst_n;
      logic [3:0] req;
      logic [3:0] exp_gnt;
      bit         exp_busy;
      logic [1:0] exp_owner;
      bit         exp_preempt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rs, input logic [3:0] r, input logic [3:0] g,
                      input bit b, input logic [1:0] o, input bit p);
      vec_t v;
      v.rst_n = rs; v.req = r; v.exp_gnt = g; v.exp_busy = b; v.exp_owner = o; v.exp_preempt = p;
      vecs.push_back(v);
   endtask

   initial begin
      logic [N-1:0] req_r;
      logic [N-1:0] don;
      bit           rs;
      int           o;

      bus_if.req    = '0;
      bus_if.drv_on = '0;

      // ---- table: reset, early release, wrap priority, reset mid-tenure ----
      add(0, 4'b1111, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 0, 0, 0);
      add(1, 4'b1111, 4'b0001, 1, 0, 0);  // t0 -> requester 0 first
      add(1, 4'b0000, 4'b0000, 0, 0, 0);  // voluntary release
      add(1, 4'b0000, 4'b0000, 0, 0, 0);  // turnaround
      add(1, 4'b0100, 4'b0100, 1, 2, 0);  // req[2] alone: 1-cycle latency
      add(1, 4'b0100, 4'b0100, 1, 2, 0);
      add(1, 4'b0100, 4'b0100, 1, 2, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);  // drop, no preempt
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b1000, 4'b1000, 1, 3, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);  // last owner = 3
      add(1, 4'b1001, 4'b0000, 0, 0, 0);  // ignored during turnaround
      add(1, 4'b1001, 4'b0001, 1, 0, 0);  // wraps to 0, not 3
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0010, 4'b0010, 1, 1, 0);  // hold 1
      add(1, 4'b0010, 4'b0010, 1, 1, 0);
      add(1, 4'b0010, 4'b0010, 1, 1, 0);
      add(1, 4'b0010, 4'b0010, 1, 1, 0);
      add(1, 4'b0010, 4'b0010, 1, 1, 0);  // hold 5
      add(0, 4'b0010, 4'b0000, 0, 0, 0);  // reset drops enable same edge
      add(1, 4'b0010, 4'b0010, 1, 1, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].rst_n, vecs[i].req, 4'b0000);
         check("vec_gnt",     32'(bus_if.gnt),     32'(vecs[i].exp_gnt));
         check("vec_drv_en",  32'(bus_if.drv_en),  32'(vecs[i].exp_gnt));
         check("vec_busy",    32'(bus_if.busy),    32'(vecs[i].exp_busy));
         check("vec_preempt", 32'(bus_if.preempt), 32'(vecs[i].exp_preempt));
         check("vec_bus_err", 32'(bus_if.bus_err), 32'(0));
         if (vecs[i].exp_busy) check("vec_owner", 32'(bus_if.owner), 32'(vecs[i].exp_owner));
         $display("vec %0d rst_n=%0b req=%b gnt=%b busy=%0b", i, vecs[i].rst_n, vecs[i].req,
                  bus_if.gnt, bus_if.busy);
      end

      // ---- round robin under full load with hold-limit preemption ----
      cycle(0, 4'b1111, 4'b0000);
      cycle(0, 4'b1111, 4'b0000);
      for (int t = 0; t < 5; t++) begin
         o = t % N;
         for (int c = 0; c < MAX_HOLD; c++) begin
            cycle(1, 4'b1111, m_gnt());
            check("rr_gnt", 32'(bus_if.drv_en), 32'(1 << o));
            check("rr_no_preempt", 32'(bus_if.preempt), 32'(0));
         end
         cycle(1, 4'b1111, m_gnt());
         check("rr_release_gnt", 32'(bus_if.drv_en), 32'(0));
         check("rr_preempt", 32'(bus_if.preempt), 32'(1));
         cycle(1, 4'b1111, m_gnt());
         check("rr_gap_gnt", 32'(bus_if.drv_en), 32'(0));
         check("rr_gap_preempt", 32'(bus_if.preempt), 32'(0));
         $display("rr tenure %0d owner %0d done at %0t", t, o, $time);
      end

      // ---- contention checker ----
      cycle(0, 4'b0001, 4'b0000);
      cycle(1, 4'b0001, 4'b0000);
      check("chk_gnt", 32'(bus_if.gnt), 32'(4'b0001));
      cycle(1, 4'b0001, 4'b0001);
      check("chk_legal", 32'(bus_if.bus_err), 32'(0));
      cycle(1, 4'b0001, 4'b0011);
      check("chk_set", 32'(bus_if.bus_err), 32'(CHK));
      for (int c = 0; c < 3; c++) begin
         cycle(1, 4'b0001, 4'b0001);
         check("chk_sticky", 32'(bus_if.bus_err), 32'(CHK));
      end
      check("chk_grant_kept", 32'(bus_if.gnt), 32'(4'b0001));
      cycle(0, 4'b0000, 4'b0000);
      check("chk_reset", 32'(bus_if.bus_err), 32'(0));
      $display("contention check done, bus_err expected %0b", CHK);

      // ---- randomized traffic against the model ----
      cycle(0, 4'b0000, 4'b0000);
      req_r = '0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) req_r ^= 4'(1 << $urandom_range(0, 3));
         rs  = ($urandom_range(0, 499) != 0);
         don = m_gnt();
         if ($urandom_range(0, 299) == 0) don = 4'($urandom);
         cycle(rs, req_r, don);
         if (m_cur >= 0 && m_ten == 1)
            $display("grant owner %0d req=%b at %0t", m_cur, req_r, $time);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
